// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state type and default geometry/timing
// values for the sensor scan sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_OUTPUT,
    ST_ADVANCE
  } scan_state_t;

  localparam int DEF_ROW_W  = 2;
  localparam int DEF_COL_W  = 2;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_SETTLE = 4;

endpackage

// File: rtl/select_decoder.sv
// select_decoder: W -> 2**W one-cold decoder with enable.
// Ports: i_en (0 forces all ones), i_sel index, o_sel_n one-cold.
module select_decoder #(
  parameter int W = 2
) (
  input  logic            i_en,
  input  logic [W-1:0]    i_sel,
  output logic [2**W-1:0] o_sel_n
);

  always_comb begin
    o_sel_n = '1;
    if (i_en) o_sel_n[i_sel] = 1'b0;
  end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: raster scan sequencer for the pixel array.
// Steps row/col, waits a settle time, fires the ADC, streams samples.
// Ports: clk, reset (async active-low), start; row_sel_n, col_addr,
// adc_start/adc_done/adc_data to the ADC; pix_data/pix_valid/
// pix_ready/pix_last downstream; busy and frame_done status.
module sensor_scan_ctrl
  import scan_pkg::*;
#(
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [2**ROW_W-1:0] row_sel_n,
  output logic [COL_W-1:0]    col_addr,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [PIX_W-1:0]    adc_data,
  output logic [PIX_W-1:0]    pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_last,
  output logic                busy,
  output logic                frame_done
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] TC = CW'(SETTLE - 1);

  scan_state_t        r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [CW-1:0]      r_cnt;
  logic [2**ROW_W-1:0] r_row_sel_n;
  logic               r_adc_start;
  logic [PIX_W-1:0]   r_pix_data;
  logic               r_pix_valid;
  logic               r_pix_last;
  logic               r_busy;
  logic               r_frame_done;

  scan_state_t        w_state_nxt;
  logic [ROW_W-1:0]   w_row_nxt;
  logic [COL_W-1:0]   w_col_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_adc_start_nxt;
  logic [PIX_W-1:0]   w_pix_data_nxt;
  logic               w_pix_valid_nxt;
  logic               w_pix_last_nxt;
  logic               w_frame_done_nxt;
  logic               w_at_end;
  logic               w_sel_en;
  logic [2**ROW_W-1:0] w_sel_n;

  assign w_at_end = (&r_row) & (&r_col);

  always_comb begin
    w_state_nxt      = r_state;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_cnt_nxt        = r_cnt;
    w_adc_start_nxt  = 1'b0;
    w_pix_data_nxt   = r_pix_data;
    w_pix_valid_nxt  = 1'b0;
    w_pix_last_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == TC) begin
          w_cnt_nxt       = '0;
          w_adc_start_nxt = 1'b1;
          w_state_nxt     = ST_CONVERT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CONVERT: begin
        if (adc_done) begin
          w_pix_data_nxt  = adc_data;
          w_pix_valid_nxt = 1'b1;
          w_pix_last_nxt  = w_at_end;
          w_state_nxt     = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        w_pix_valid_nxt = 1'b1;
        w_pix_last_nxt  = r_pix_last;
        if (pix_ready) begin
          w_pix_valid_nxt = 1'b0;
          w_pix_last_nxt  = 1'b0;
          if (r_pix_last) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = ST_IDLE;
          end else begin
            w_state_nxt = ST_ADVANCE;
          end
        end
      end
      ST_ADVANCE: begin
        // column is the fast index; row steps on column wrap
        w_col_nxt = r_col + 1'b1;
        if (&r_col) w_row_nxt = r_row + 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SETTLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // decode the next row so the select lines come straight from a flop
  assign w_sel_en = (w_state_nxt != ST_IDLE);

  select_decoder #(
    .W(ROW_W)
  ) u_row_dec (
    .i_en   (w_sel_en),
    .i_sel  (w_row_nxt),
    .o_sel_n(w_sel_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_cnt        <= '0;
      r_row_sel_n  <= '1;
      r_adc_start  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_cnt        <= w_cnt_nxt;
      r_row_sel_n  <= w_sel_n;
      r_adc_start  <= w_adc_start_nxt;
      r_pix_data   <= w_pix_data_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_pix_last   <= w_pix_last_nxt;
      r_busy       <= w_sel_en;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign row_sel_n  = r_row_sel_n;
  assign col_addr   = r_col;
  assign adc_start  = r_adc_start;
  assign pix_data   = r_pix_data;
  assign pix_valid  = r_pix_valid;
  assign pix_last   = r_pix_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: randomized self-checking bench for the scan
// sequencer, default geometry plus an 8x2 / settle-1 instance.
module tb_sensor_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // ---------------- default instance ----------------
  logic       rst_n;
  logic       start;
  logic [3:0] row_sel_n;
  logic [1:0] col_addr;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_last;
  logic       busy;
  logic       frame_done;

  sensor_scan_ctrl u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .row_sel_n (row_sel_n),
    .col_addr  (col_addr),
    .adc_start (adc_start),
    .adc_done  (adc_done),
    .adc_data  (adc_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // ---------------- 8x2, settle 1 instance ----------------
  logic       start2;
  logic [7:0] row_sel_n2;
  logic [0:0] col_addr2;
  logic       adc_start2;
  logic       adc_done2;
  logic [7:0] adc_data2;
  logic [7:0] pix_data2;
  logic       pix_valid2;
  logic       pix_ready2;
  logic       pix_last2;
  logic       busy2;
  logic       frame_done2;

  assign pix_ready2 = 1'b1;

  sensor_scan_ctrl #(
    .ROW_W (3),
    .COL_W (1),
    .PIX_W (8),
    .SETTLE(1)
  ) u_dut2 (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start2),
    .row_sel_n (row_sel_n2),
    .col_addr  (col_addr2),
    .adc_start (adc_start2),
    .adc_done  (adc_done2),
    .adc_data  (adc_data2),
    .pix_data  (pix_data2),
    .pix_valid (pix_valid2),
    .pix_ready (pix_ready2),
    .pix_last  (pix_last2),
    .busy      (busy2),
    .frame_done(frame_done2)
  );

  // ---------------- environment state ----------------
  int         lat_mode = 2;   // <0: random 0..3 cycles
  int         rdy_mode = 0;   // 0 high, 1 random, 2 low
  bit         stray_en = 1'b0;
  logic [7:0] salt     = 8'h00;
  logic [7:0] salt2    = 8'h00;

  logic [7:0] pix_q[$];
  bit         last_q[$];
  int         fd_cnt  = 0;
  int         ast_cnt = 0;
  int         viol    = 0;

  logic [7:0] pix2_q[$];
  bit         last2_q[$];
  logic [7:0] rsel2_q[$];
  int         ast2_t[$];
  int         fd2_cnt = 0;
  int         viol2   = 0;
  int         cyc2    = 0;

  function automatic int dec_row(logic [7:0] v, int n);
    int r;
    r = -1;
    for (int i = 0; i < n; i++)
      if (v[i] == 1'b0) r = i;
    return r;
  endfunction

  // raster pixel k of a frame must carry k ^ salt
  function automatic int frame_errs(logic [7:0] s, int base);
    int e;
    logic [7:0] x;
    e = 0;
    if (pix_q.size() - base != 16) return 99;
    for (int i = 0; i < 16; i++) begin
      x = 8'(i) ^ s;
      if (pix_q[base+i] !== x) e++;
      if (last_q[base+i] !== (i == 15)) e++;
    end
    return e;
  endfunction

  // ADC, downstream sink and property monitor for the default instance
  initial begin : drv1
    int a_cnt;
    int a_row;
    int a_col;
    int stray_cnt;
    bit prev_ast;
    bit prev_hold;
    bit prev_busy;
    logic [7:0] prev_data;
    adc_done  = 1'b0;
    adc_data  = '0;
    pix_ready = 1'b1;
    a_cnt = -1; a_row = 0; a_col = 0; stray_cnt = 0;
    prev_ast = 0; prev_hold = 0; prev_busy = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (!rst_n) begin
        a_cnt = -1; stray_cnt = 0;
        prev_ast = 0; prev_hold = 0; prev_busy = 0;
      end else begin
        if ($countones(~row_sel_n) > 1) viol++;
        if (adc_start && prev_ast) viol++;
        if (prev_hold && (!pix_valid || pix_data !== prev_data)) viol++;
        if (frame_done && (busy || !prev_busy)) viol++;
        prev_ast = adc_start;
        if (frame_done) fd_cnt++;
        if (adc_start) begin
          ast_cnt++;
          a_row = dec_row({4'hF, row_sel_n}, 4);
          a_col = int'(col_addr);
          a_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (a_cnt == 0) begin
          adc_done = 1'b1;
          adc_data = 8'(a_row * 4 + a_col) ^ salt;
          a_cnt = -1;
        end else if (a_cnt > 0) begin
          a_cnt--;
        end else if (stray_cnt > 0) begin
          stray_cnt--;
          if (stray_cnt == 0) begin
            adc_done = 1'b1;
            adc_data = 8'hEE;
          end
        end
        case (rdy_mode)
          1:       pix_ready = 1'($urandom_range(0, 1));
          2:       pix_ready = 1'b0;
          default: pix_ready = 1'b1;
        endcase
        if (pix_valid && pix_ready) begin
          pix_q.push_back(pix_data);
          last_q.push_back(pix_last);
          if (stray_en && !pix_last) stray_cnt = 2;
        end
        prev_hold = pix_valid && !pix_ready;
        prev_data = pix_data;
        prev_busy = busy;
      end
    end
  end

  // zero-latency ADC and sink for the 8x2 instance
  initial begin : drv2
    adc_done2 = 1'b0;
    adc_data2 = '0;
    forever begin
      @(negedge clk);
      adc_done2 = 1'b0;
      cyc2++;
      if (rst_n) begin
        if ($countones(~row_sel_n2) > 1) viol2++;
        if (frame_done2) fd2_cnt++;
        if (adc_start2) begin
          ast2_t.push_back(cyc2);
          rsel2_q.push_back(row_sel_n2);
          adc_done2 = 1'b1;
          adc_data2 = 8'(dec_row(row_sel_n2, 8) * 2 + int'(col_addr2))
                      ^ salt2;
        end
        if (pix_valid2) begin
          pix2_q.push_back(pix_data2);
          last2_q.push_back(pix_last2);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_frame(input int base, output bit ok);
    int t;
    t = 0;
    while (fd_cnt == base && t < 3000) begin
      @(negedge clk); t++;
    end
    ok = (fd_cnt != base);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (row_sel_n !== 4'hF) $display("FAIL rst_rowsel got %h want f", row_sel_n);
    else n_pass++;
    n_chk++;
    if (col_addr !== 2'd0) $display("FAIL rst_col got %0d want 0", col_addr);
    else n_pass++;
    n_chk++;
    if (adc_start !== 1'b0) $display("FAIL rst_adcst got %b want 0", adc_start);
    else n_pass++;
    n_chk++;
    if (pix_data !== 8'h00) $display("FAIL rst_pixd got %h want 00", pix_data);
    else n_pass++;
    n_chk++;
    if ({pix_valid, pix_last} !== 2'b00)
      $display("FAIL rst_valid_last got %b want 00", {pix_valid, pix_last});
    else n_pass++;
    n_chk++;
    if ({busy, frame_done} !== 2'b00)
      $display("FAIL rst_busy_fd got %b want 00", {busy, frame_done});
    else n_pass++;
    n_chk++;
    if (row_sel_n2 !== 8'hFF) $display("FAIL rst_rowsel2 got %h want ff", row_sel_n2);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    int k;
    int base;
    int fb;
    bit ok;
    salt = 8'h00; lat_mode = 2; rdy_mode = 0;
    base = pix_q.size(); fb = fd_cnt;
    pulse_start();
    n_chk++;
    if ({busy, row_sel_n, col_addr} !== {1'b1, 4'hE, 2'd0})
      $display("FAIL tm_entry got busy=%b sel=%h col=%0d want 1 e 0",
               busy, row_sel_n, col_addr);
    else n_pass++;
    k = 0;
    while (!adc_start && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k !== 4) $display("FAIL tm_settle got %0d want 4", k);
    else n_pass++;
    k = 0;
    while (!pix_valid && k < 20) begin @(negedge clk); k++; end
    n_chk++;
    if (k !== 3 || pix_data !== 8'h00)
      $display("FAIL tm_conv got lat=%0d d=%h want 3 00", k, pix_data);
    else n_pass++;
    wait_frame(fb, ok);
    n_chk++;
    if (!ok) $display("FAIL tm_frame_timeout got 0 want 1");
    else n_pass++;
    n_chk++;
    if (frame_errs(salt, base) !== 0)
      $display("FAIL tm_pixels got %0d errs want 0", frame_errs(salt, base));
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || fd_cnt - fb !== 1)
      $display("FAIL tm_after got busy=%b fds=%0d want 0 1", busy, fd_cnt - fb);
    else n_pass++;
  endtask

  task automatic test_random();
    int base;
    int fb;
    bit ok;
    lat_mode = -1; rdy_mode = 1;
    for (int f = 0; f < 4; f++) begin
      salt = 8'($urandom);
      base = pix_q.size(); fb = fd_cnt;
      pulse_start();
      wait_frame(fb, ok);
      n_chk++;
      if (!ok || frame_errs(salt, base) !== 0)
        $display("FAIL rand_frame%0d got ok=%b errs=%0d want 1 0",
                 f, ok, frame_errs(salt, base));
      else n_pass++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_stall();
    int base;
    int fb;
    int k;
    int a;
    bit ok;
    logic [7:0] d;
    logic [3:0] r;
    logic [1:0] c;
    salt = 8'($urandom); lat_mode = -1; rdy_mode = 2;
    base = pix_q.size(); fb = fd_cnt;
    pulse_start();
    k = 0;
    while (!pix_valid && k < 100) begin @(negedge clk); k++; end
    d = pix_data; r = row_sel_n; c = col_addr; a = ast_cnt;
    repeat (5) @(negedge clk);
    n_chk++;
    if (!pix_valid || pix_data !== d || pix_data !== salt)
      $display("FAIL stall_hold got v=%b d=%h want 1 %h", pix_valid, pix_data, salt);
    else n_pass++;
    n_chk++;
    if (row_sel_n !== r || col_addr !== c || ast_cnt !== a || pix_q.size() !== base)
      $display("FAIL stall_frozen got sel=%h col=%0d st=%0d want %h %0d %0d",
               row_sel_n, col_addr, ast_cnt, r, c, a);
    else n_pass++;
    rdy_mode = 0;
    wait_frame(fb, ok);
    n_chk++;
    if (!ok || frame_errs(salt, base) !== 0)
      $display("FAIL stall_frame got ok=%b errs=%0d want 1 0",
               ok, frame_errs(salt, base));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    int fb;
    int k;
    bit ok;
    salt = 8'($urandom); lat_mode = 3; rdy_mode = 0;
    base = pix_q.size(); fb = fd_cnt;
    pulse_start();
    k = 0;
    while (!(adc_start && col_addr == 2'd2 && row_sel_n == 4'hD) && k < 500) begin
      @(negedge clk); k++;
    end
    n_chk++;
    if (pix_q.size() - base !== 6)
      $display("FAIL rmid_count got %0d want 6", pix_q.size() - base);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({row_sel_n, col_addr, adc_start, pix_data, pix_valid, pix_last, busy,
         frame_done} !== {4'hF, 2'd0, 1'b0, 8'h00, 4'h0})
      $display("FAIL rmid_outs got sel=%h col=%0d st=%b d=%h v=%b l=%b b=%b fd=%b",
               row_sel_n, col_addr, adc_start, pix_data, pix_valid, pix_last,
               busy, frame_done);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    salt = 8'($urandom); lat_mode = -1;
    base = pix_q.size(); fb = fd_cnt;
    pulse_start();
    wait_frame(fb, ok);
    n_chk++;
    if (!ok || frame_errs(salt, base) !== 0)
      $display("FAIL rmid_restart got ok=%b errs=%0d want 1 0",
               ok, frame_errs(salt, base));
    else n_pass++;
  endtask

  task automatic test_ignore();
    int base;
    int fb;
    int k;
    bit ok;
    salt = 8'($urandom); lat_mode = -1; rdy_mode = 1; stray_en = 1'b1;
    base = pix_q.size(); fb = fd_cnt;
    pulse_start();
    k = 0;
    while (pix_q.size() - base < 3 && k < 500) begin @(negedge clk); k++; end
    pulse_start();
    wait_frame(fb, ok);
    stray_en = 1'b0; rdy_mode = 0;
    n_chk++;
    if (!ok || frame_errs(salt, base) !== 0)
      $display("FAIL ign_frame got ok=%b errs=%0d want 1 0",
               ok, frame_errs(salt, base));
    else n_pass++;
    repeat (30) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || fd_cnt - fb !== 1 || pix_q.size() - base !== 16)
      $display("FAIL ign_noqueue got busy=%b fds=%0d px=%0d want 0 1 16",
               busy, fd_cnt - fb, pix_q.size() - base);
    else n_pass++;
  endtask

  task automatic test_params();
    int k;
    int e_px;
    int e_sel;
    int e_per;
    logic [7:0] x;
    logic [7:0] es;
    salt2 = 8'($urandom);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = 0;
    while (fd2_cnt == 0 && k < 500) begin @(negedge clk); k++; end
    n_chk++;
    if (fd2_cnt !== 1 || pix2_q.size() !== 16 || rsel2_q.size() !== 16)
      $display("FAIL p2_count got fd=%0d px=%0d st=%0d want 1 16 16",
               fd2_cnt, pix2_q.size(), rsel2_q.size());
    else n_pass++;
    e_px = 0; e_sel = 0; e_per = 0;
    if (pix2_q.size() == 16 && rsel2_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        x = 8'(i) ^ salt2;
        if (pix2_q[i] !== x || last2_q[i] !== (i == 15)) e_px++;
        es = 8'hFF;
        es[i/2] = 1'b0;
        if (rsel2_q[i] !== es) e_sel++;
        if (i > 0 && ast2_t[i] - ast2_t[i-1] != 4) e_per++;
      end
    end
    n_chk++;
    if (e_px !== 0) $display("FAIL p2_pixels got %0d errs want 0", e_px);
    else n_pass++;
    n_chk++;
    if (e_sel !== 0) $display("FAIL p2_rowsel got %0d errs want 0", e_sel);
    else n_pass++;
    n_chk++;
    if (e_per !== 0) $display("FAIL p2_period got %0d errs want 0", e_per);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy2 !== 1'b0 || row_sel_n2 !== 8'hFF)
      $display("FAIL p2_idle got b=%b sel=%h want 0 ff", busy2, row_sel_n2);
    else n_pass++;
  endtask

  task automatic test_assertions();
    n_chk++;
    if (viol !== 0) $display("FAIL props got %0d violations want 0", viol);
    else n_pass++;
    n_chk++;
    if (viol2 !== 0) $display("FAIL props2 got %0d violations want 0", viol2);
    else n_pass++;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    test_reset();
    test_timing();
    test_random();
    test_stall();
    test_reset_mid();
    test_ignore();
    test_params();
    test_assertions();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
